// File: rtl/preparo_pkg.sv
// Shared encodings for the drink-order sequencer: controller states,
// selection-machine status codes and the drink codes it displays.
package preparo_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ESCOLHA  = 3'd1,
        AQUECE   = 3'd2,
        CAFE     = 3'd3,
        LEITE    = 3'd4,
        AGUA     = 3'd5,
        FINALIZA = 3'd6,
        CANCELA  = 3'd7
    } etapa_t;

    typedef enum logic [1:0] {
        ANALISANDO   = 2'b00,
        MOSTRANDO    = 2'b01,
        NAO_ESCOLHEU = 2'b10,
        ESCOLHEU     = 2'b11
    } saida_esc_t;

    localparam logic [3:0] D_ESPRESSO   = 4'b0001;
    localparam logic [3:0] D_CAFE_LEITE = 4'b0010;
    localparam logic [3:0] D_CHA        = 4'b0011;
    localparam logic [3:0] D_CAPPUCCINO = 4'b0100;

endpackage

// File: rtl/contador_etapa.sv
// Loadable down-counter timing one recipe step; holds at zero once it gets there.
module contador_etapa #(
    parameter int W = 9
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CARGA,
    input  logic [W-1:0] VALOR,
    output logic         ZERO
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N)
            cnt <= '0;
        else if (CARGA)
            cnt <= VALOR;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign ZERO = (cnt == '0);

endmodule

// File: rtl/sequenciador_preparo.sv
// Sequences one drink order: selection window, boiler heat-up, timed valve
// recipe, then completion or cancel. Every output is a flop fed from next state.
module sequenciador_preparo
    import preparo_pkg::*;
#(
    parameter int TIMEOUT_CYC  = 50,
    parameter int T_AQUECE_MAX = 200,
    parameter int T_CAFE       = 40,
    parameter int T_LEITE      = 30,
    parameter int T_AGUA       = 60,
    parameter int CNT_W        = 9
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       INICIA,
    input  logic       ABORTA,
    input  logic [1:0] SAIDA_ESC,
    input  logic [3:0] DRINK,
    input  logic       TEMP_OK,
    output logic       TIMER,
    output logic       REINICIA_ESC,
    output logic       AQUECEDOR,
    output logic       VALV_CAFE,
    output logic       VALV_LEITE,
    output logic       VALV_AGUA,
    output logic       OCUPADO,
    output logic       PRONTO,
    output logic       ERRO,
    output logic [2:0] ETAPA
);

    localparam logic [CNT_W-1:0] L_TIMER   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] L_ESC_MAX = CNT_W'(2 * TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] L_AQ_MAX  = CNT_W'(T_AQUECE_MAX - 1);
    localparam logic [CNT_W-1:0] L_CAFE    = CNT_W'(T_CAFE - 1);
    localparam logic [CNT_W-1:0] L_LEITE   = CNT_W'(T_LEITE - 1);
    localparam logic [CNT_W-1:0] L_LEITE2  = CNT_W'(2 * T_LEITE - 1);
    localparam logic [CNT_W-1:0] L_AGUA    = CNT_W'(T_AGUA - 1);

    etapa_t           estado, prox;
    logic [CNT_W-1:0] cnt, cnt_prox;
    logic [3:0]       bebida, bebida_prox;
    logic             erro_prox;
    logic             carga;
    logic [CNT_W-1:0] valor;
    logic             zero;

    contador_etapa #(.W(CNT_W)) u_contador (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CARGA (carga),
        .VALOR (valor),
        .ZERO  (zero)
    );

    always_comb begin
        prox        = estado;
        cnt_prox    = cnt;
        bebida_prox = bebida;
        erro_prox   = ERRO;
        carga       = 1'b0;
        valor       = '0;
        case (estado)
            OCIOSO: if (INICIA) begin
                prox      = ESCOLHA;
                cnt_prox  = '0;
                erro_prox = 1'b0;
            end
            ESCOLHA: begin
                cnt_prox = cnt + CNT_W'(1);
                if (SAIDA_ESC == ESCOLHEU) begin
                    prox        = AQUECE;
                    bebida_prox = DRINK;
                    cnt_prox    = '0;
                end else if (SAIDA_ESC == NAO_ESCOLHEU || cnt == L_ESC_MAX) begin
                    prox = CANCELA;
                end
            end
            AQUECE: begin
                cnt_prox = cnt + CNT_W'(1);
                if (TEMP_OK) begin
                    case (bebida)
                        D_ESPRESSO, D_CAFE_LEITE, D_CAPPUCCINO: begin
                            prox  = CAFE;
                            carga = 1'b1;
                            valor = L_CAFE;
                        end
                        D_CHA: begin
                            prox  = AGUA;
                            carga = 1'b1;
                            valor = L_AGUA;
                        end
                        default: prox = CANCELA;
                    endcase
                end else if (cnt == L_AQ_MAX) begin
                    prox      = CANCELA;
                    erro_prox = 1'b1;
                end
            end
            CAFE: if (zero) begin
                if (bebida == D_ESPRESSO) begin
                    prox = FINALIZA;
                end else begin
                    prox  = LEITE;
                    carga = 1'b1;
                    valor = (bebida == D_CAPPUCCINO) ? L_LEITE2 : L_LEITE;
                end
            end
            LEITE, AGUA: if (zero) prox = FINALIZA;
            default: prox = OCIOSO;
        endcase
        // A cancel overrides whatever the active state decided this cycle.
        if (ABORTA && estado inside {ESCOLHA, AQUECE, CAFE, LEITE, AGUA}) begin
            prox        = CANCELA;
            bebida_prox = bebida;
            erro_prox   = ERRO;
            carga       = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            estado       <= OCIOSO;
            cnt          <= '0;
            bebida       <= '0;
            TIMER        <= 1'b0;
            REINICIA_ESC <= 1'b0;
            AQUECEDOR    <= 1'b0;
            VALV_CAFE    <= 1'b0;
            VALV_LEITE   <= 1'b0;
            VALV_AGUA    <= 1'b0;
            OCUPADO      <= 1'b0;
            PRONTO       <= 1'b0;
            ERRO         <= 1'b0;
        end else begin
            estado       <= prox;
            cnt          <= cnt_prox;
            bebida       <= bebida_prox;
            TIMER        <= (prox == ESCOLHA) && (cnt_prox == L_TIMER);
            REINICIA_ESC <= (prox == FINALIZA) || (prox == CANCELA);
            AQUECEDOR    <= (prox == AQUECE);
            VALV_CAFE    <= (prox == CAFE);
            VALV_LEITE   <= (prox == LEITE);
            VALV_AGUA    <= (prox == AGUA);
            OCUPADO      <= (prox != OCIOSO);
            PRONTO       <= (prox == FINALIZA);
            ERRO         <= erro_prox;
        end
    end

    assign ETAPA = estado;

endmodule

// File: tb/tb_sequenciador_preparo.sv
// Bench for sequenciador_preparo: scenario tasks compare observed output
// activity against durations derived from the drink recipes.
module tb_sequenciador_preparo;

    localparam int TO  = 50;
    localparam int TAQ = 200;
    localparam int TC  = 40;
    localparam int TL  = 30;
    localparam int TA  = 60;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       INICIA = 1'b0;
    logic       ABORTA = 1'b0;
    logic [1:0] SAIDA_ESC = 2'b00;
    logic [3:0] DRINK = 4'd0;
    logic       TEMP_OK = 1'b0;
    logic       TIMER, REINICIA_ESC, AQUECEDOR, VALV_CAFE, VALV_LEITE, VALV_AGUA;
    logic       OCUPADO, PRONTO, ERRO;
    logic [2:0] ETAPA;

    sequenciador_preparo #(
        .TIMEOUT_CYC(TO), .T_AQUECE_MAX(TAQ), .T_CAFE(TC),
        .T_LEITE(TL), .T_AGUA(TA), .CNT_W(9)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .INICIA(INICIA), .ABORTA(ABORTA),
        .SAIDA_ESC(SAIDA_ESC), .DRINK(DRINK), .TEMP_OK(TEMP_OK),
        .TIMER(TIMER), .REINICIA_ESC(REINICIA_ESC), .AQUECEDOR(AQUECEDOR),
        .VALV_CAFE(VALV_CAFE), .VALV_LEITE(VALV_LEITE), .VALV_AGUA(VALV_AGUA),
        .OCUPADO(OCUPADO), .PRONTO(PRONTO), .ERRO(ERRO), .ETAPA(ETAPA)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_cafe, n_leite, n_agua, n_aq, n_timer, n_rein, n_pronto, n_ocup;
    int n_overlap, n_handoff, timer_at;
    logic prev_cafe;

    task automatic clear_obs();
        n_cafe = 0; n_leite = 0; n_agua = 0; n_aq = 0; n_timer = 0; n_rein = 0;
        n_pronto = 0; n_ocup = 0; n_overlap = 0; n_handoff = 0; timer_at = -1;
        prev_cafe = 1'b0;
    endtask

    // One clock, then observe the registered outputs 1 time unit later.
    task automatic clk1();
        @(posedge CLK);
        #1;
        cyc++;
        if (VALV_CAFE) n_cafe++;
        if (VALV_LEITE) n_leite++;
        if (VALV_AGUA) n_agua++;
        if (AQUECEDOR) n_aq++;
        if (REINICIA_ESC) n_rein++;
        if (PRONTO) n_pronto++;
        if (OCUPADO) n_ocup++;
        if (TIMER) begin n_timer++; timer_at = cyc; end
        if (int'(VALV_CAFE) + int'(VALV_LEITE) + int'(VALV_AGUA) > 1) n_overlap++;
        if (prev_cafe && VALV_LEITE) n_handoff++;
        prev_cafe = VALV_CAFE;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int i;
        i = 0;
        while (OCUPADO && i < budget) begin
            clk1();
            i++;
        end
        checks++;
        if (OCUPADO) begin
            errors++;
            $display("FAIL %s_bound still busy after %0d cycles", nm, budget);
        end
    endtask

    // Valve open times per drink code, straight from the recipe table.
    function automatic void receita(input logic [3:0] d, output int c, output int l, output int a);
        c = 0; l = 0; a = 0;
        case (d)
            4'd1: c = TC;
            4'd2: begin c = TC; l = TL; end
            4'd3: a = TA;
            4'd4: begin c = TC; l = 2 * TL; end
            default: ;
        endcase
    endfunction

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) clk1();
        checks++;
        if ({TIMER, REINICIA_ESC, AQUECEDOR, VALV_CAFE, VALV_LEITE, VALV_AGUA,
             OCUPADO, PRONTO, ERRO, ETAPA} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp all zero",
                {TIMER, REINICIA_ESC, AQUECEDOR, VALV_CAFE, VALV_LEITE, VALV_AGUA,
                 OCUPADO, PRONTO, ERRO, ETAPA});
        end
        RST_N = 1'b1;
        clk1();
        checks++;
        if (ETAPA !== 3'd0 || OCUPADO !== 1'b0) begin
            errors++;
            $display("FAIL reset_release etapa=%0d ocupado=%b exp 0/0", ETAPA, OCUPADO);
        end
    endtask

    // Full order: verdict after v cycles of "drink shown", heat ready after h cycles.
    task automatic test_order(input logic [3:0] d, input int v, input int h);
        int ec, el, ea, start;
        logic [15:0] exp_q[$];
        logic [15:0] obs_q[$];
        string nm_q[$];
        receita(d, ec, el, ea);
        clear_obs();
        INICIA = 1'b1;
        clk1();
        INICIA = 1'b0;
        start = cyc;
        SAIDA_ESC = 2'b01;
        repeat (v) clk1();
        SAIDA_ESC = 2'b11;
        DRINK = d;
        clk1();
        SAIDA_ESC = 2'b00;
        TEMP_OK = 1'b0;
        repeat (h) clk1();
        TEMP_OK = 1'b1;
        wait_idle(400, "order");
        TEMP_OK = 1'b0;

        nm_q = '{"cafe", "leite", "agua", "aquece", "ocupado", "pronto",
                 "reinicia", "timer", "handoff", "overlap", "erro", "etapa"};
        exp_q.push_back(16'(ec));                    obs_q.push_back(16'(n_cafe));
        exp_q.push_back(16'(el));                    obs_q.push_back(16'(n_leite));
        exp_q.push_back(16'(ea));                    obs_q.push_back(16'(n_agua));
        exp_q.push_back(16'(h + 1));                 obs_q.push_back(16'(n_aq));
        exp_q.push_back(16'(v + h + ec + el + ea + 3)); obs_q.push_back(16'(n_ocup));
        exp_q.push_back(16'((ec + ea > 0) ? 1 : 0)); obs_q.push_back(16'(n_pronto));
        exp_q.push_back(16'(1));                     obs_q.push_back(16'(n_rein));
        exp_q.push_back(16'((v >= TO - 1) ? 1 : 0)); obs_q.push_back(16'(n_timer));
        exp_q.push_back(16'((el > 0) ? 1 : 0));      obs_q.push_back(16'(n_handoff));
        exp_q.push_back(16'(0));                     obs_q.push_back(16'(n_overlap));
        exp_q.push_back(16'(0));                     obs_q.push_back(16'(ERRO));
        exp_q.push_back(16'(0));                     obs_q.push_back(16'(ETAPA));
        if (v >= TO - 1) begin
            nm_q.push_back("timer_pos");
            exp_q.push_back(16'(TO - 1));
            obs_q.push_back(16'(timer_at - start));
        end
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL order_%s drink=%0d v=%0d h=%0d got %0d exp %0d",
                    nm_q[i], d, v, h, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_orders();
        int r;
        logic [3:0] d;
        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(0, 5);
            if (r < 4) d = 4'(r + 1);
            else if (r == 4) d = 4'd0;
            else d = 4'($urandom_range(5, 15));
            test_order(d, $urandom_range(0, 60), $urandom_range(0, 15));
        end
    endtask

    task automatic test_timeout();
        int start, extra;
        clear_obs();
        extra = $urandom_range(1, 40);
        INICIA = 1'b1;
        clk1();
        INICIA = 1'b0;
        start = cyc;
        SAIDA_ESC = 2'b00;
        repeat (TO - 1 + extra) clk1();
        checks++;
        if (n_timer !== 1 || timer_at - start !== TO - 1) begin
            errors++;
            $display("FAIL timeout_timer pulses=%0d at=%0d exp 1 at %0d", n_timer, timer_at - start, TO - 1);
        end
        SAIDA_ESC = 2'b10;
        clk1();
        SAIDA_ESC = 2'b00;
        checks++;
        if (ETAPA !== 3'd7 || REINICIA_ESC !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cancel etapa=%0d reinicia=%b exp 7/1", ETAPA, REINICIA_ESC);
        end
        clk1();
        checks++;
        if (ETAPA !== 3'd0 || n_cafe + n_leite + n_agua + n_aq !== 0 || n_rein !== 1) begin
            errors++;
            $display("FAIL timeout_end etapa=%0d actuators=%0d reinicia=%0d exp 0/0/1",
                ETAPA, n_cafe + n_leite + n_agua + n_aq, n_rein);
        end
        // No verdict at all: the window closes by itself.
        clear_obs();
        INICIA = 1'b1;
        clk1();
        INICIA = 1'b0;
        wait_idle(300, "no_verdict");
        checks++;
        if (n_ocup !== 2 * TO + 1 || n_timer !== 1 || n_rein !== 1 || n_pronto !== 0) begin
            errors++;
            $display("FAIL no_verdict ocupado=%0d timer=%0d reinicia=%0d pronto=%0d exp %0d/1/1/0",
                n_ocup, n_timer, n_rein, n_pronto, 2 * TO + 1);
        end
    endtask

    task automatic test_heat_fault();
        clear_obs();
        INICIA = 1'b1;
        clk1();
        INICIA = 1'b0;
        repeat ($urandom_range(0, 10)) clk1();
        SAIDA_ESC = 2'b11;
        DRINK = 4'd3;
        TEMP_OK = 1'b0;
        clk1();
        SAIDA_ESC = 2'b00;
        wait_idle(400, "heat_fault");
        checks++;
        if (n_aq !== TAQ || n_agua !== 0 || ERRO !== 1'b1 || n_rein !== 1 || n_pronto !== 0) begin
            errors++;
            $display("FAIL heat_fault aquece=%0d agua=%0d erro=%b reinicia=%0d pronto=%0d exp %0d/0/1/1/0",
                n_aq, n_agua, ERRO, n_rein, n_pronto, TAQ);
        end
        repeat (3) clk1();
        checks++;
        if (ERRO !== 1'b1) begin
            errors++;
            $display("FAIL heat_fault_sticky erro=%b exp 1", ERRO);
        end
        INICIA = 1'b1;
        clk1();
        INICIA = 1'b0;
        checks++;
        if (ERRO !== 1'b0 || ETAPA !== 3'd1) begin
            errors++;
            $display("FAIL heat_fault_clear erro=%b etapa=%0d exp 0/1", ERRO, ETAPA);
        end
        ABORTA = 1'b1;
        clk1();
        ABORTA = 1'b0;
        clk1();
    endtask

    task automatic test_abort_leite();
        clear_obs();
        INICIA = 1'b1;
        clk1();
        INICIA = 1'b0;
        SAIDA_ESC = 2'b11;
        DRINK = 4'd2;
        TEMP_OK = 1'b1;
        clk1();
        SAIDA_ESC = 2'b00;
        for (int i = 0; i < 200 && n_leite < 10; i++) clk1();
        ABORTA = 1'b1;
        clk1();
        ABORTA = 1'b0;
        TEMP_OK = 1'b0;
        checks++;
        if (VALV_LEITE !== 1'b0 || REINICIA_ESC !== 1'b1 || ETAPA !== 3'd7 || n_leite !== 10) begin
            errors++;
            $display("FAIL abort_leite leite=%b reinicia=%b etapa=%0d leite_cycles=%0d exp 0/1/7/10",
                VALV_LEITE, REINICIA_ESC, ETAPA, n_leite);
        end
        wait_idle(10, "abort_leite");
        checks++;
        if (n_pronto !== 0 || n_rein !== 1 || n_cafe !== TC) begin
            errors++;
            $display("FAIL abort_leite_end pronto=%0d reinicia=%0d cafe=%0d exp 0/1/%0d",
                n_pronto, n_rein, n_cafe, TC);
        end
    endtask

    task automatic test_abort_priority();
        ABORTA = 1'b1;
        clk1();
        checks++;
        if (ETAPA !== 3'd0 || OCUPADO !== 1'b0 || REINICIA_ESC !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle etapa=%0d ocupado=%b reinicia=%b exp 0/0/0", ETAPA, OCUPADO, REINICIA_ESC);
        end
        ABORTA = 1'b0;
        INICIA = 1'b1;
        clk1();
        INICIA = 1'b0;
        SAIDA_ESC = 2'b11;
        DRINK = 4'd1;
        ABORTA = 1'b1;
        clk1();
        ABORTA = 1'b0;
        SAIDA_ESC = 2'b00;
        checks++;
        if (ETAPA !== 3'd7 || AQUECEDOR !== 1'b0) begin
            errors++;
            $display("FAIL abort_vs_verdict etapa=%0d aquecedor=%b exp 7/0", ETAPA, AQUECEDOR);
        end
        clk1();
        INICIA = 1'b1;
        clk1();
        INICIA = 1'b0;
        SAIDA_ESC = 2'b11;
        clk1();
        SAIDA_ESC = 2'b00;
        TEMP_OK = 1'b1;
        ABORTA = 1'b1;
        clk1();
        ABORTA = 1'b0;
        TEMP_OK = 1'b0;
        checks++;
        if (ETAPA !== 3'd7 || VALV_CAFE !== 1'b0 || AQUECEDOR !== 1'b0) begin
            errors++;
            $display("FAIL abort_vs_temp etapa=%0d cafe=%b aquecedor=%b exp 7/0/0", ETAPA, VALV_CAFE, AQUECEDOR);
        end
        clk1();
    endtask

    task automatic test_reset_mid_agua();
        int k;
        k = $urandom_range(5, 50);
        clear_obs();
        INICIA = 1'b1;
        clk1();
        INICIA = 1'b0;
        SAIDA_ESC = 2'b11;
        DRINK = 4'd3;
        TEMP_OK = 1'b1;
        clk1();
        SAIDA_ESC = 2'b00;
        for (int i = 0; i < 200 && n_agua < k; i++) clk1();
        INICIA = 1'b1;
        clk1();
        checks++;
        if (ETAPA !== 3'd5 || VALV_AGUA !== 1'b1 || n_agua !== k + 1) begin
            errors++;
            $display("FAIL inicia_busy etapa=%0d agua=%b agua_cycles=%0d exp 5/1/%0d", ETAPA, VALV_AGUA, n_agua, k + 1);
        end
        RST_N = 1'b0;
        clk1();
        checks++;
        if ({TIMER, REINICIA_ESC, AQUECEDOR, VALV_CAFE, VALV_LEITE, VALV_AGUA,
             OCUPADO, PRONTO, ERRO, ETAPA} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_agua got %b exp all zero",
                {TIMER, REINICIA_ESC, AQUECEDOR, VALV_CAFE, VALV_LEITE, VALV_AGUA,
                 OCUPADO, PRONTO, ERRO, ETAPA});
        end
        RST_N = 1'b1;
        INICIA = 1'b0;
        TEMP_OK = 1'b0;
        clk1();
        checks++;
        if (ETAPA !== 3'd0 || VALV_AGUA !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_agua_after etapa=%0d agua=%b exp 0/0", ETAPA, VALV_AGUA);
        end
    endtask

    initial begin
        test_reset();
        test_order(4'd1, 5, 0);
        test_order(4'd4, $urandom_range(0, 20), $urandom_range(0, 10));
        test_order(4'd2, TO - 1, 3);
        test_random_orders();
        test_timeout();
        test_heat_fault();
        test_abort_leite();
        test_abort_priority();
        test_reset_mid_agua();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequenciador_preparo.md
Name: sequenciador_preparo

Overview:
Controller that sequences one drink order from start to delivery. It opens the selection window, drives the selection machine's inactivity timer and waits for its verdict. It then runs the recipe for the chosen drink (heat, coffee, milk, water) on timed valve outputs and returns the selection machine to its analysis state when the order ends. It sits between the front-panel start/abort buttons, the selection FSM and the actuator drivers.

Parameters:
TIMEOUT_CYC, 50, cycles in ESCOLHA before a TIMER pulse is issued to the selection machine
T_AQUECE_MAX, 200, maximum cycles waiting for TEMP_OK before fault
T_CAFE, 40, coffee valve open time in cycles
T_LEITE, 30, milk valve open time in cycles (cappuccino uses 2*T_LEITE)
T_AGUA, 60, hot-water valve open time in cycles (tea)
CNT_W, 9, width of step/timeout counters; must hold 2*TIMEOUT_CYC, 2*T_LEITE and T_AQUECE_MAX

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  synchronous active-low reset
INICIA  in  1  start request (one-cycle pulse or level; sampled only in OCIOSO)
ABORTA  in  1  user cancel, sampled every cycle
SAIDA_ESC  in  2  selection machine status: 00 analysing, 01 drink shown, 11 chosen, 10 not chosen
DRINK  in  4  selection machine display code: 0001 espresso, 0010 cafe com leite, 0011 cha, 0100 cappuccino
TEMP_OK  in  1  boiler at temperature
TIMER  out  1  one-cycle timeout pulse to selection machine
REINICIA_ESC  out  1  one-cycle pulse forcing selection machine back to ANALISE
AQUECEDOR  out  1  heater enable
VALV_CAFE  out  1  coffee valve
VALV_LEITE  out  1  milk valve
VALV_AGUA  out  1  hot-water valve
OCUPADO  out  1  high in every state except OCIOSO
PRONTO  out  1  one-cycle pulse on successful completion
ERRO  out  1  sticky heat-timeout fault; cleared by reset or accepted INICIA
ETAPA  out  3  current state encoding, for display/debug

Behaviour:
- Reset (RST_N low at a rising edge): state OCIOSO; all outputs 0; latched drink code 0; counters 0.
- All outputs are registered. Valve and heater outputs are high exactly while in their own state.
- States: OCIOSO, ESCOLHA, AQUECE, CAFE, LEITE, AGUA, FINALIZA, CANCELA.
- OCIOSO:
  - INICIA=1 -> ESCOLHA next cycle, timeout counter cleared, ERRO cleared.
  - ABORTA is ignored in this state.
- ESCOLHA:
  - Counter increments every cycle. When it equals TIMEOUT_CYC-1, TIMER pulses high for one cycle; no further TIMER pulses in this visit.
  - SAIDA_ESC=11 -> latch DRINK -> AQUECE.
  - SAIDA_ESC=10 -> CANCELA.
  - Counter reaching 2*TIMEOUT_CYC-1 with no verdict -> CANCELA.
  - If SAIDA_ESC=11 is seen on the same cycle as the TIMER pulse, 11 wins.
- AQUECE:
  - TEMP_OK sampled high -> go to the first recipe step. Minimum 1 cycle in AQUECE.
  - T_AQUECE_MAX cycles without TEMP_OK -> CANCELA with ERRO=1.
- Recipe by latched code:
  - 0001: CAFE(T_CAFE)
  - 0010: CAFE(T_CAFE) then LEITE(T_LEITE)
  - 0011: AGUA(T_AGUA)
  - 0100: CAFE(T_CAFE) then LEITE(2*T_LEITE)
  - Any other code -> CANCELA from AQUECE exit, ERRO unchanged.
- Timed steps: on entry the counter loads T-1. The step exits when the counter is 0, so its valve is high exactly T cycles. Back-to-back steps have no gap cycle.
- The last step -> FINALIZA.
- FINALIZA: PRONTO=1 and REINICIA_ESC=1 for one cycle, then OCIOSO.
- CANCELA: REINICIA_ESC=1 for one cycle, all valves/heater 0, then OCIOSO.
- ABORTA=1 in any state other than OCIOSO/FINALIZA/CANCELA -> CANCELA next cycle.
  - ABORTA has priority over step completion, verdicts and TEMP_OK.
  - Outputs drop on the same edge.
- INICIA outside OCIOSO is ignored. Reset mid-recipe closes all valves on that edge.

Decomposition:
- Package preparo_pkg:
  - state encodings (3 bits)
  - drink codes 0001..0100
  - SAIDA_ESC codes (ANALISANDO=00, MOSTRANDO=01, ESCOLHEU=11, NAO_ESCOLHEU=10)
- Sub-module contador_etapa: loadable down-counter.
  - Ports: CLK, RST_N, CARGA, VALOR, ZERO.
  - Instantiated for step timing.
- The ESCOLHA/AQUECE up-counter stays inline.

Test Plan:
- Espresso: INICIA, SAIDA_ESC=01 then 11 with DRINK=0001 at cycle 5, TEMP_OK high -> VALV_CAFE high exactly 40 cycles, then PRONTO and REINICIA_ESC pulse once, ETAPA back to OCIOSO.
- Cappuccino: DRINK=0100 -> VALV_CAFE 40 cycles immediately followed by VALV_LEITE 60 cycles, no gap, no overlap.
- Timeout: INICIA, SAIDA_ESC held 00 -> TIMER single pulse at cycle 49 after ESCOLHA entry; SAIDA_ESC=10 next -> CANCELA, REINICIA_ESC pulse, no valve ever high.
- Heat fault: chosen 0011, TEMP_OK held 0 -> AQUECEDOR high 200 cycles, then ERRO=1 sticky, VALV_AGUA never high; next INICIA clears ERRO.
- Abort mid-step: ABORTA at cycle 10 of LEITE (DRINK=0010) -> VALV_LEITE low next edge, REINICIA_ESC pulse, PRONTO never asserted.
- Reset mid-AGUA: RST_N low one cycle -> all outputs 0, state OCIOSO, INICIA while OCUPADO ignored beforehand.
